// File: rtl/gear_n8_arb_ctrl.sv
// Two-requester round-robin front end for an approximate 8-bit adder.
// Flags approximation errors, optionally substitutes the exact sum, and counts errors.
module gear_n8_arb_ctrl #(
  parameter int SAT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [7:0]       req0_in1,
  input  logic [7:0]       req0_in2,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_in1,
  input  logic [7:0]       req1_in2,
  output logic             req1_ready,
  input  logic             corr_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8:0]       out_res,
  output logic             out_id,
  output logic             out_err,
  output logic             out_corr,
  output logic [SAT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_CORR, S_OUT} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_op1;
  logic [7:0]       r_op2;
  logic             r_cur_id;
  logic             r_last_id;
  logic [8:0]       r_out_res;
  logic             r_out_id;
  logic             r_out_err;
  logic             r_out_corr;
  logic [SAT_W-1:0] r_err_cnt;

  logic             w_grant_any;
  logic             w_grant_id;
  logic [5:0]       w_lo;
  logic [2:0]       w_hi_top;
  logic [8:0]       w_approx;
  logic [8:0]       w_exact;
  logic             w_err;

  // Contested cycles go to whoever did not win last; a lone requester always wins.
  assign w_grant_any = req0_valid | req1_valid;
  assign w_grant_id  = (req0_valid & req1_valid) ? ~r_last_id : req1_valid;

  // Only lo[5:0] and hi[6:4] reach the result, so the sums are trimmed to those bits.
  assign w_lo     = r_op1[5:0] + r_op2[5:0];
  assign w_hi_top = 3'(({1'b0, r_op1[7:2]} + {1'b0, r_op2[7:2]}) >> 4);
  assign w_approx = {w_hi_top, w_lo};
  assign w_exact  = {1'b0, r_op1} + {1'b0, r_op2};
  assign w_err    = (w_approx != w_exact);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_grant_any) w_state_next = S_CALC;
      S_CALC: w_state_next = (w_err && corr_en) ? S_CORR : S_OUT;
      S_CORR: w_state_next = S_OUT;
      S_OUT:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    out_valid  = 1'b0;
    if (r_state == S_IDLE && !rst && w_grant_any) begin
      req0_ready = ~w_grant_id;
      req1_ready = w_grant_id;
    end
    if (r_state == S_OUT) out_valid = 1'b1;
  end

  // Result registers only move on CALC/CORR loads, so they hold through OUT and IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op1      <= '0;
      r_op2      <= '0;
      r_cur_id   <= 1'b0;
      r_last_id  <= 1'b1;
      r_out_res  <= '0;
      r_out_id   <= 1'b0;
      r_out_err  <= 1'b0;
      r_out_corr <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_op1     <= w_grant_id ? req1_in1 : req0_in1;
            r_op2     <= w_grant_id ? req1_in2 : req0_in2;
            r_cur_id  <= w_grant_id;
            r_last_id <= w_grant_id;
          end
        end
        S_CALC: begin
          if (w_err && (r_err_cnt != {SAT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + SAT_W'(1);
          end
          if (!(w_err && corr_en)) begin
            r_out_res  <= w_approx;
            r_out_id   <= r_cur_id;
            r_out_err  <= w_err;
            r_out_corr <= 1'b0;
          end
        end
        S_CORR: begin
          r_out_res  <= w_exact;
          r_out_id   <= r_cur_id;
          r_out_err  <= 1'b1;
          r_out_corr <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_res  = r_out_res;
  assign out_id   = r_out_id;
  assign out_err  = r_out_err;
  assign out_corr = r_out_corr;
  assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_gear_n8_arb_ctrl.sv
// Directed bench for gear_n8_arb_ctrl: latency, correction, arbitration, stall, reset drop.
// A narrow error counter is used so saturation is reachable in a few transactions.
module tb_gear_n8_arb_ctrl;
  localparam int SAT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic [7:0]       req0_in1, req0_in2, req1_in1, req1_in2;
  logic             req0_ready, req1_ready;
  logic             corr_en;
  logic             out_valid, out_ready;
  logic [8:0]       out_res;
  logic             out_id, out_err, out_corr;
  logic [SAT_W-1:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gear_n8_arb_ctrl #(.SAT_W(SAT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_ready(req1_ready),
    .corr_en(corr_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_id(out_id), .out_err(out_err), .out_corr(out_corr),
    .err_cnt(err_cnt)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one pair from requester id while in IDLE, waits (bounded) for out_valid,
  // checks latency and result, then completes the handshake with out_ready=1.
  task automatic do_txn(input string tag, input logic id, input logic [7:0] a, input logic [7:0] b,
                        input logic ce, input logic [8:0] e_res, input logic e_err,
                        input logic e_corr, input int e_lat, input logic [SAT_W-1:0] e_cnt);
    int lat;
    corr_en   = ce;
    out_ready = 1'b1;
    if (id) begin req1_valid = 1'b1; req1_in1 = a; req1_in2 = b; end
    else    begin req0_valid = 1'b1; req0_in1 = a; req0_in2 = b; end
    #1;
    check({tag, ".rdy"}, {14'd0, req1_ready, req0_ready}, id ? 16'd2 : 16'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      tick();
      lat++;
    end
    check({tag, ".lat"},  16'(lat), 16'(e_lat));
    check({tag, ".res"},  16'(out_res), 16'(e_res));
    check({tag, ".id"},   16'(out_id), 16'(id));
    check({tag, ".err"},  16'(out_err), 16'(e_err));
    check({tag, ".corr"}, 16'(out_corr), 16'(e_corr));
    check({tag, ".cnt"},  16'(err_cnt), 16'(e_cnt));
    tick();
    check({tag, ".idle"}, 16'(out_valid), 16'd0);
  endtask

  initial begin
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b0;
    req0_in1 = 8'h00; req0_in2 = 8'h00; req1_in1 = 8'h00; req1_in2 = 8'h00;
    corr_en = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("rst.rdy0",  16'(req0_ready), 16'd0);
    check("rst.valid", 16'(out_valid), 16'd0);
    check("rst.res",   16'(out_res), 16'd0);
    check("rst.flags", {13'd0, out_id, out_err, out_corr}, 16'd0);
    check("rst.cnt",   16'(err_cnt), 16'd0);
    req0_valid = 1'b0;
    rst = 1'b0;
    tick();

    do_txn("basic",   1'b0, 8'h12, 8'h34, 1'b1, 9'h046, 1'b0, 1'b0, 2, 2'd0);
    do_txn("err_nc",  1'b1, 8'h3F, 8'h01, 1'b0, 9'h000, 1'b1, 1'b0, 2, 2'd1);
    do_txn("err_c",   1'b1, 8'h3F, 8'h01, 1'b1, 9'h040, 1'b1, 1'b1, 3, 2'd2);
    check("hold.res", 16'(out_res), 16'h040);
    do_txn("err_3",   1'b0, 8'h3F, 8'h01, 1'b0, 9'h000, 1'b1, 1'b0, 2, 2'd3);
    do_txn("sat",     1'b0, 8'h3F, 8'h01, 1'b1, 9'h040, 1'b1, 1'b1, 3, 2'd3);

    // Output stall: result must stay put and nothing new may be accepted.
    corr_en = 1'b0; out_ready = 1'b0;
    req0_valid = 1'b1; req0_in1 = 8'hFF; req0_in2 = 8'hFF;
    #1;
    check("stall.acc", 16'(req0_ready), 16'd1);
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d.valid", k), 16'(out_valid), 16'd1);
      check($sformatf("stall%0d.res", k), 16'(out_res), 16'h1FE);
      check($sformatf("stall%0d.rdy", k), 16'(req0_ready), 16'd0);
      if (k < 4) tick();
    end
    req0_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("stall.done", 16'(out_valid), 16'd0);
    check("stall.keep", 16'(out_res), 16'h1FE);

    // Reset while in CORR drops the pair.
    corr_en = 1'b1;
    req1_valid = 1'b1; req1_in1 = 8'h3F; req1_in2 = 8'h01;
    tick();
    req1_valid = 1'b0;
    tick();
    rst = 1'b1; req0_valid = 1'b1;
    #1;
    check("drop.rdy_rst", {14'd0, req1_ready, req0_ready}, 16'd0);
    tick();
    rst = 1'b0; req0_valid = 1'b0;
    check("drop.valid", 16'(out_valid), 16'd0);
    check("drop.res",   16'(out_res), 16'd0);
    check("drop.flags", {13'd0, out_id, out_err, out_corr}, 16'd0);
    check("drop.cnt",   16'(err_cnt), 16'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("drop%0d.valid", k), 16'(out_valid), 16'd0);
    end

    // Both requesters valid continuously: grants alternate starting with 0.
    corr_en = 1'b0; out_ready = 1'b1;
    req0_valid = 1'b1; req0_in1 = 8'h01; req0_in2 = 8'h02;
    req1_valid = 1'b1; req1_in1 = 8'h04; req1_in2 = 8'h05;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr%0d.grant", k), {14'd0, req1_ready, req0_ready},
            (k % 2 == 0) ? 16'd1 : 16'd2);
      tick();
      check($sformatf("rr%0d.calc_rdy", k), {14'd0, req1_ready, req0_ready}, 16'd0);
      tick();
      check($sformatf("rr%0d.valid", k), 16'(out_valid), 16'd1);
      check($sformatf("rr%0d.id", k), 16'(out_id), 16'(k % 2));
      check($sformatf("rr%0d.res", k), 16'(out_res), (k % 2 == 0) ? 16'h003 : 16'h009);
      check($sformatf("rr%0d.out_rdy", k), {14'd0, req1_ready, req0_ready}, 16'd0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
